// File: rtl/radix8_pkg.sv
// Shared sizing helpers and build-time latency for the radix-8 multiple
// preprocessor. Build macro: RADIX8_PRE_2STAGE_EN selects the two-register
// pipeline (latency 2). Left undefined, the block is single-stage (latency 1).
package radix8_pkg;

`ifdef RADIX8_PRE_2STAGE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // |x| never needs more bits than the operand:
    // signed -2^(W-1) maps to 2^(W-1), which still fits.
    function automatic int mag_w(input int data_w);
        return data_w;
    endfunction

    // 3*(2^W - 1) < 2^(W+2)
    function automatic int m3_w(input int data_w);
        return data_w + 2;
    endfunction

    // 7*(2^W - 1) < 2^(W+3), which also covers 5X
    function automatic int m57_w(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/radix8_pipe_slice.sv
// One valid/ready register slice carrying an arbitrary packed payload type.
//
// Handshake: a beat moves across an interface on a rising clk edge when valid
// and ready are both high. in_ready = !valid_q | out_ready, so a full slice
// accepts a new beat in the same cycle its held beat leaves (no bubble).
// The payload is held bit-stable while the slice is stalled, and it keeps its
// last value after it drains.
module radix8_pipe_slice #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic valid_q, valid_d;
    T     data_q,  data_d;

    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next state: load on an input transfer, otherwise empty on an output transfer.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slice registers. An asynchronous clear drops any beat that is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/radix8_premult_pipe.sv
// Radix-8 multiplier preprocessor. Each lane receives an operand and produces
// the magnitude multiples 1X/3X/5X/7X and a sign flag. All lanes share one
// valid/ready handshake.
// Build macro: RADIX8_PRE_2STAGE_EN places a register between the magnitude
// step and the multiple step (latency 2). The default build is a single
// register (latency 1). Both builds have the same port list.
module radix8_premult_pipe
    import radix8_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        iValid,
    output logic                        oReady,
    input  logic                        iSigned,
    input  logic [LANES*DATA_W-1:0]     iDat,
    output logic                        oValid,
    input  logic                        iReady,
    output logic [LANES*DATA_W-1:0]     oDat1X,
    output logic [LANES*(DATA_W+2)-1:0] oDat3X,
    output logic [LANES*(DATA_W+3)-1:0] oDat5X,
    output logic [LANES*(DATA_W+3)-1:0] oDat7X,
    output logic [LANES-1:0]            oNegative
);

    localparam int W1  = mag_w(DATA_W);
    localparam int W3  = m3_w(DATA_W);
    localparam int W57 = m57_w(DATA_W);

    // The lane records are declared here because their field widths follow DATA_W.
    typedef struct packed {
        logic          neg;
        logic [W1-1:0] d1x;
    } mag_lane_t;

    typedef struct packed {
        logic           neg;
        logic [W1-1:0]  d1x;
        logic [W3-1:0]  d3x;
        logic [W57-1:0] d5x;
        logic [W57-1:0] d7x;
    } lane_t;

    typedef mag_lane_t [LANES-1:0] mag_beat_t;
    typedef lane_t     [LANES-1:0] beat_t;

    mag_beat_t mag_in;    // magnitude/sign of the operands presented this cycle
    mag_beat_t mult_src;  // magnitude/sign that feeds the multiple generator
    beat_t     mult_out;  // complete lane records that feed the output slice
    beat_t     out_beat;  // registered lane records that drive the ports

    // Magnitude step. In signed mode, a set MSB is negated in DATA_W bits, so the
    // most-negative value maps exactly to 2^(DATA_W-1).
    for (genvar g = 0; g < LANES; g++) begin : g_mag
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] x_inv;
        logic              neg;
        assign x             = iDat[g*DATA_W +: DATA_W];
        assign x_inv         = ~x;
        assign neg           = iSigned & x[DATA_W-1];
        assign mag_in[g].neg = neg;
        assign mag_in[g].d1x = neg ? (x_inv + DATA_W'(1)) : x;
    end

    // Multiple step. The magnitude is zero-extended to the widest result, so the
    // shifts, the adds and the subtract cannot overflow.
    for (genvar g = 0; g < LANES; g++) begin : g_mult
        logic [W57-1:0] m;
        logic [W57-1:0] m3;
        assign m               = W57'(mult_src[g].d1x);
        assign m3              = m + (m << 1);
        assign mult_out[g].neg = mult_src[g].neg;
        assign mult_out[g].d1x = mult_src[g].d1x;
        assign mult_out[g].d3x = m3[W3-1:0];
        assign mult_out[g].d5x = m + (m << 2);
        assign mult_out[g].d7x = (m << 3) - m;
    end

`ifdef RADIX8_PRE_2STAGE_EN
    logic a_valid;
    logic a_ready;

    // Stage A registers the magnitude and sign. Stage B registers the multiples.
    radix8_pipe_slice #(.T(mag_beat_t)) u_stage_a (
        .clk       (clk),
        .rst_n     (rst),
        .in_valid  (iValid),
        .in_ready  (oReady),
        .in_data   (mag_in),
        .out_valid (a_valid),
        .out_ready (a_ready),
        .out_data  (mult_src)
    );

    radix8_pipe_slice #(.T(beat_t)) u_stage_b (
        .clk       (clk),
        .rst_n     (rst),
        .in_valid  (a_valid),
        .in_ready  (a_ready),
        .in_data   (mult_out),
        .out_valid (oValid),
        .out_ready (iReady),
        .out_data  (out_beat)
    );
`else
    assign mult_src = mag_in;

    // Single stage: the magnitude and the multiples are computed combinationally
    // from the input, then registered once.
    radix8_pipe_slice #(.T(beat_t)) u_stage_b (
        .clk       (clk),
        .rst_n     (rst),
        .in_valid  (iValid),
        .in_ready  (oReady),
        .in_data   (mult_out),
        .out_valid (oValid),
        .out_ready (iReady),
        .out_data  (out_beat)
    );
`endif

    // Spread the registered lane records onto the flat output buses.
    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign oDat1X[g*W1  +: W1 ] = out_beat[g].d1x;
        assign oDat3X[g*W3  +: W3 ] = out_beat[g].d3x;
        assign oDat5X[g*W57 +: W57] = out_beat[g].d5x;
        assign oDat7X[g*W57 +: W57] = out_beat[g].d7x;
        assign oNegative[g]         = out_beat[g].neg;
    end

endmodule
